seq_checker: RTL and testbench

//  Player-side counterpart of the Genius sequence ROMs. It walks the ROM address, reads the expected one-hot colour and

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_onehot_chk.sv | 12 +
 rtl/seq_checker.sv | 114 +++++++++++
 tb/tb_seq_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the Genius player-side sequence checker: state codes,
// colour width and the one-hot colour values held in the sequence ROM.
package seq_pkg;

  localparam int NCOR = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ESPERA = 2'd1;
  localparam logic [1:0] ST_OK     = 2'd2;
  localparam logic [1:0] ST_FALHA  = 2'd3;

  localparam logic [NCOR-1:0] COR_0 = 4'b0001;
  localparam logic [NCOR-1:0] COR_1 = 4'b0010;
  localparam logic [NCOR-1:0] COR_2 = 4'b0100;
  localparam logic [NCOR-1:0] COR_3 = 4'b1000;

endpackage

// File: rtl/seq_onehot_chk.sv
// Combinational one-hot detector: valid is high when exactly one bit of vec is set.
module seq_onehot_chk #(
  parameter int W = 4
) (
  input  logic [W-1:0] vec,
  output logic         valid
);

  // Clearing the lowest set bit leaves zero only for single-bit words.
  assign valid = (vec != '0) && ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/seq_checker.sv
// Player-side sequence checker: walks the ROM address and compares each button
// press with the expected colour. Optional per-press timeout under SEQ_TIMEOUT_EN.
module seq_checker #(
  parameter int SIZE           = 4,
  parameter int NCOR           = seq_pkg::NCOR,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] nivel,
  input  logic [NCOR-1:0] botoes,
  input  logic [NCOR-1:0] esperado,
  output logic [SIZE-1:0] address,
  output logic            ocupado,
  output logic            acerto,
  output logic            erro
);

  import seq_pkg::*;

  logic [1:0]      state_reg, state_next;
  logic [SIZE-1:0] addr_reg, addr_next;
  logic [SIZE-1:0] nivel_reg, nivel_next;
  logic            ocupado_reg, acerto_reg, erro_reg;
  logic            press_valid;
  logic            press_any;
  logic            press_ok;
  logic            tmo_hit;

  seq_onehot_chk #(.W(NCOR)) u_onehot (
    .vec   (botoes),
    .valid (press_valid)
  );

  assign press_any = (botoes != '0);
  assign press_ok  = press_valid && (botoes == esperado);

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt_reg;

  // Held at zero outside ESPERA, so it starts from zero on every entry.
  always_ff @(posedge clk) begin
    if (reset || (state_reg != ST_ESPERA) || (press_any && press_ok)) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    nivel_next = nivel_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          nivel_next = nivel;
          addr_next  = '0;
          state_next = ST_ESPERA;
        end
      end
      ST_ESPERA: begin
        // A press in the timeout cycle wins over the timeout.
        if (press_any) begin
          if (!press_ok) begin
            state_next = ST_FALHA;
          end else if (addr_reg == nivel_reg) begin
            state_next = ST_OK;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end else if (tmo_hit) begin
          state_next = ST_FALHA;
        end
      end
      default: begin
        addr_next  = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      nivel_reg   <= '0;
      ocupado_reg <= 1'b0;
      acerto_reg  <= 1'b0;
      erro_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      nivel_reg   <= nivel_next;
      ocupado_reg <= (state_next == ST_ESPERA);
      acerto_reg  <= (state_next == ST_OK);
      erro_reg    <= (state_next == ST_FALHA);
    end
  end

  assign address = addr_reg;
  assign ocupado = ocupado_reg;
  assign acerto  = acerto_reg;
  assign erro    = erro_reg;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a round-level model.
module tb_seq_checker;

  localparam int SIZE = 4;
  localparam int NCOR = 4;
  localparam int TMO  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [SIZE-1:0] nivel = '0;
  logic [NCOR-1:0] botoes = '0;
  logic [NCOR-1:0] esperado;
  logic [SIZE-1:0] address;
  logic            ocupado, acerto, erro;

  logic [NCOR-1:0] rom [16];
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign esperado = rom[address];

  seq_checker #(.SIZE(SIZE), .NCOR(NCOR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .nivel    (nivel),
    .botoes   (botoes),
    .esperado (esperado),
    .address  (address),
    .ocupado  (ocupado),
    .acerto   (acerto),
    .erro     (erro)
  );

  task automatic check(string name, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Round-level model: is a round open, which position is next, and which
  // result pulse (0 none, 1 acerto, 2 erro) is showing this cycle.
  bit m_active = 1'b0;
  int m_pos = 0, m_last = 0, m_res = 0, m_wait = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0; m_pos = 0; m_res = 0; m_wait = 0;
      chk_en = 1'b1;
    end else if (m_res != 0) begin
      m_res = 0; m_pos = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_pos = 0; m_last = int'(nivel); m_wait = 0;
      end
    end else if (botoes != '0) begin
      if (botoes == rom[m_pos]) begin
        if (m_pos == m_last) begin
          m_active = 1'b0; m_res = 1;
        end else begin
          m_pos++; m_wait = 0;
        end
      end else begin
        m_active = 1'b0; m_res = 2;
      end
    end
`ifdef SEQ_TIMEOUT_EN
    else if (m_wait == TMO - 1) begin
      m_active = 1'b0; m_res = 2;
    end else begin
      m_wait++;
    end
`endif
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_address", int'(address), m_pos);
      check("cyc_ocupado", int'(ocupado), int'(m_active));
      check("cyc_acerto", int'(acerto), int'(m_res == 1));
      check("cyc_erro", int'(erro), int'(m_res == 2));
    end
  end

  task automatic cyc(bit r, bit s, int n, logic [NCOR-1:0] b);
    reset = r; start = s; nivel = n[SIZE-1:0]; botoes = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rom[0] = 4'b0001; rom[1] = 4'b1000; rom[2] = 4'b0100; rom[3] = 4'b1000;
    for (int i = 4; i < 16; i++) rom[i] = 4'b0001 << ((i * 3 + 1) % 4);

    cyc(1, 0, 0, 4'b0000);
    check("rst_address", int'(address), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_acerto", int'(acerto), 0);
    check("rst_erro", int'(erro), 0);

    // Round of three correct presses; nivel changes after start are ignored.
    cyc(0, 1, 2, 4'b0000);
    check("t1_ocupado", int'(ocupado), 1);
    check("t1_addr0", int'(address), 0);
    cyc(0, 0, 0, 4'b0001); check("t1_addr1", int'(address), 1);
    cyc(0, 0, 0, 4'b1000); check("t1_addr2", int'(address), 2);
    cyc(0, 0, 0, 4'b0100);
    check("t1_acerto", int'(acerto), 1);
    check("t1_erro", int'(erro), 0);
    cyc(0, 0, 0, 4'b0000);
    check("t1_acerto_off", int'(acerto), 0);
    check("t1_idle_addr", int'(address), 0);
    check("t1_idle_ocupado", int'(ocupado), 0);

    // Wrong colour on the second press.
    cyc(0, 1, 3, 4'b0000);
    cyc(0, 0, 0, 4'b0001);
    cyc(0, 0, 0, 4'b0100);
    check("t2_erro", int'(erro), 1);
    check("t2_acerto", int'(acerto), 0);
    cyc(0, 0, 0, 4'b0000);
    check("t2_erro_off", int'(erro), 0);
    check("t2_addr", int'(address), 0);
    check("t2_ocupado", int'(ocupado), 0);

    // Multi-bit press, then a press while idle, then start with a press together.
    cyc(0, 1, 1, 4'b0000);
    cyc(0, 0, 0, 4'b1001);
    check("t3_erro", int'(erro), 1);
    cyc(0, 0, 0, 4'b0000);
    cyc(0, 0, 0, 4'b0001);
    check("t3_idle_acerto", int'(acerto), 0);
    check("t3_idle_erro", int'(erro), 0);
    check("t3_idle_ocupado", int'(ocupado), 0);
    cyc(0, 1, 0, 4'b0001);
    check("t3_startpress_ocupado", int'(ocupado), 1);
    check("t3_startpress_addr", int'(address), 0);
    cyc(0, 0, 0, 4'b0001);
    check("t3_single_acerto", int'(acerto), 1);
    cyc(0, 0, 0, 4'b0000);

    // Reset mid-round, then a nivel=0 round.
    cyc(0, 1, 3, 4'b0000);
    cyc(0, 0, 0, 4'b0001);
    cyc(0, 0, 0, 4'b1000);
    check("t4_addr_before_rst", int'(address), 2);
    cyc(1, 0, 0, 4'b0000);
    check("t4_rst_addr", int'(address), 0);
    check("t4_rst_ocupado", int'(ocupado), 0);
    cyc(0, 1, 0, 4'b0000);
    cyc(0, 0, 0, 4'b0001);
    check("t4_acerto", int'(acerto), 1);
    check("t4_addr", int'(address), 0);
    cyc(0, 0, 0, 4'b0000);

    // Full-length round with a stray start in the middle.
    cyc(0, 1, 15, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      cyc(0, i == 5, 0, rom[i]);
      if (i < 15) check("t5_addr", int'(address), i + 1);
    end
    check("t5_acerto", int'(acerto), 1);
    check("t5_addr_max", int'(address), 15);
    cyc(0, 0, 0, 4'b0000);
    check("t5_idle_addr", int'(address), 0);

`ifdef SEQ_TIMEOUT_EN
    begin
      int early_erro;
      cyc(0, 1, 0, 4'b0000);
      early_erro = 0;
      for (int k = 1; k < TMO; k++) begin
        cyc(0, 0, 0, 4'b0000);
        early_erro += int'(erro);
      end
      check("t6_no_early_erro", early_erro, 0);
      cyc(0, 0, 0, 4'b0000);
      check("t6_timeout_erro", int'(erro), 1);
      cyc(0, 0, 0, 4'b0000);

      cyc(0, 1, 1, 4'b0000);
      for (int k = 1; k < TMO; k++) cyc(0, 0, 0, 4'b0000);
      cyc(0, 0, 0, 4'b0001);
      check("t6_late_press_erro", int'(erro), 0);
      check("t6_late_press_addr", int'(address), 1);
      check("t6_late_press_ocupado", int'(ocupado), 1);
      cyc(0, 0, 0, 4'b1000);
      check("t6_late_round_acerto", int'(acerto), 1);
      cyc(0, 0, 0, 4'b0000);
    end
`endif

    // Randomized traffic; the per-cycle compare process checks everything.
    for (int t = 0; t < 4000; t++) begin
      bit r, s;
      int n, x;
      logic [NCOR-1:0] b;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 5) == 0);
      n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      x = int'($urandom_range(0, 9));
      if (x < 5)      b = 4'b0000;
      else if (x < 8) b = rom[m_pos];
      else            b = 4'($urandom_range(1, 15));
      cyc(r, s, n, b);
    end

    cyc(0, 0, 0, 4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
